piton_endp_yummy_port: RTL
==========================

# piton_endp_yummy_port

Endpoint-side adapter that attaches to the LOCAL port of a `piton_router_top`. On transmit, it turns a ready/valid flit stream from the tile into the router's valid/data/yummy credit protocol, tracking downstream buffer credits. On receive, it buffers router-delivered flits in a small FIFO, presents them to the tile as ready/valid, and returns one yummy per flit the tile consumes. One instance per endpoint sits between the tile logic and `chan_in_all[i]` / `chan_out_all[i]` of `piton_mesh`.

## Interface
Parameters:
- `FLIT_W`, 64: flit width; must equal the width of `piton_chan_t.data`.
- `CREDITS`, 4: depth of the router's local input buffer, which is the initial TX credit count.
- `RX_DEPTH`, 4: RX FIFO depth. Must be a power of two and ≥ the credit count the router holds for its LOCAL output.
- `CW`, `$clog2(CREDITS+1)`: width of the credit counter (derived, not user-set).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data_i`  in  FLIT_W  flit from the tile.
- `tx_valid_i`  in  1  TX flit valid.
- `tx_ready_o`  out  1  TX can accept (at least one credit available).
- `chan_out`  out  piton_chan_t  to router LOCAL `chan_in`: valid, data, yummy.
- `chan_in`  in  piton_chan_t  from router LOCAL `chan_out`: valid, data, yummy.
- `rx_data_o`  out  FLIT_W  head flit of the RX FIFO.
- `rx_valid_o`  out  1  RX FIFO is non-empty.
- `rx_ready_i`  in  1  tile consumes the head flit.
- `credit_cnt_o`  out  CW  current TX credit count.
- `rx_overflow_o`  out  1  sticky: a flit arrived while the RX FIFO was full.
- `credit_err_o`  out  1  sticky: a yummy arrived while credits were already at `CREDITS`.
- `tx_flits_o`, `rx_flits_o`  out  32 each  flit statistics counters (see Configuration).

## Operation
- **TX accept.** `tx_ready_o = (credit != 0)`, decoded from the registered counter with no combinational path from `chan_in`. A flit is accepted when `tx_valid_i & tx_ready_o`.
- **TX output.** On accept, `chan_out.valid` is set to 1 and `chan_out.data` to `tx_data_i` in the next cycle. Otherwise `chan_out.valid` is 0 and `chan_out.data` holds its last value.
- **Credit update.**
  - Accept only: credit − 1.
  - `chan_in.yummy` only: credit + 1.
  - Both in the same cycle: credit unchanged.
  - Yummy with no accept while credit == `CREDITS`: counter holds and `credit_err_o` is set.
- **RX push.** `chan_in.valid` writes `chan_in.data` at the tail of the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the flit is dropped and `rx_overflow_o` is set.
  - Push and pop in the same cycle while full: both take effect and occupancy stays at `RX_DEPTH`.
- **RX pop.** The FIFO is first-word fall-through: `rx_data_o` shows the head whenever `rx_valid_o = 1`. A pop happens on `rx_valid_o & rx_ready_i`.
- **Yummy return.** Each pop produces a one-cycle `chan_out.yummy` pulse in the next cycle. Back-to-back pops produce back-to-back pulses.
- **Pointers and occupancy.**
  - Read and write pointers are log2(`RX_DEPTH`) bits and wrap naturally.
  - Occupancy is tracked in a counter one bit wider.
  - Full is `count == RX_DEPTH`; empty is `count == 0`.
- **Error flags.** Both sticky flags clear only on reset.

## Timing
- **Reset values.**
  - 0: `chan_out.valid`, `chan_out.yummy`, `chan_out.data`, `rx_valid_o`, `rx_data_o`, both error flags, both statistics counters.
  - `credit_cnt_o = CREDITS` and `tx_ready_o = 1` (given `CREDITS > 0`).
- **Latencies.**
  - TX accept to `chan_out.valid`: 1 cycle.
  - `chan_in.valid` to `rx_valid_o` when the FIFO is empty: 1 cycle.
  - Pop to `chan_out.yummy`: 1 cycle.
  - Yummy to `tx_ready_o` rising from 0: 1 cycle.
- **Throughput.** Sustained 1 flit/cycle in each direction while credits and space remain.
- **Reset mid-operation.** FIFO contents are discarded, no yummies are returned for them, and the credit count reinitialises. The router must be reset in the same cycle.

## Configuration
- Macro: `PITON_PORT_STATS_EN`.
- **Defined.**
  - `tx_flits_o` increments on each TX accept.
  - `rx_flits_o` increments on each RX push, including dropped flits.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- **Not defined.** Both outputs are tied to constant 0, no counter registers exist, and all other behaviour is identical.

## Structure
- `piton_chan_t` and the flit-width constant come from `piton_pkg`. Defaults for `CREDITS` and `RX_DEPTH` are added to `piton_pkg` as localparams, next to the channel type.
- One sub-module, `piton_port_fifo`: a parameterised synchronous FWFT FIFO with push, pop, full, empty and count. The credit counter and yummy logic stay in the top module.

## Test plan
- **Reset defaults:** assert `reset` for 2 cycles → `credit_cnt_o = 4`, `tx_ready_o = 1`, all other outputs 0.
- **Credit exhaustion and recovery:** drive 5 back-to-back TX flits `0x1..0x5` with no yummies → 4 accepted and seen on `chan_out` on cycles 1–4, `tx_ready_o = 0` after the 4th. One yummy → flit `0x5` accepted on the following cycle.
- **Simultaneous accept and yummy:** credit = 2, accept and yummy in the same cycle → `credit_cnt_o` stays 2.
- **RX ordering and yummy pacing:** push `0xA`, `0xB`, `0xC` with `rx_ready_i = 0`, then hold `rx_ready_i = 1` → outputs `A, B, C` in order, each followed one cycle later by a yummy pulse, 3 pulses total.
- **Overflow vs. full-with-pop:**
  - Fill the FIFO with 4 flits, push a 5th with no pop → flit dropped, `rx_overflow_o = 1` and stays 1.
  - Repeat after reset, pushing the 5th in the same cycle as a pop → no overflow, occupancy stays 4.
- **Statistics (macro defined):** 10 TX accepts and 7 RX pushes → `tx_flits_o = 10`, `rx_flits_o = 7`. With the macro undefined, both read 0.

Source files
------------

// File: rtl/piton_pkg.sv
// Shared piton mesh types: the router channel bundle and endpoint port defaults.
package piton_pkg;

    localparam int PITON_FLIT_W = 64;

    typedef struct packed {
        logic                    valid;
        logic [PITON_FLIT_W-1:0] data;
        logic                    yummy;
    } piton_chan_t;

    localparam int PORT_CREDITS  = 4;
    localparam int PORT_RX_DEPTH = 4;

endpackage

// File: rtl/piton_port_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word reads as zero while empty.
module piton_port_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/piton_endp_yummy_port.sv
// Endpoint adapter between tile ready/valid streams and a router LOCAL valid/yummy port.
// Optional flit statistics counters are enabled by defining PITON_PORT_STATS_EN.
module piton_endp_yummy_port
    import piton_pkg::*;
#(
    parameter  int FLIT_W   = PITON_FLIT_W,
    parameter  int CREDITS  = PORT_CREDITS,
    parameter  int RX_DEPTH = PORT_RX_DEPTH,
    localparam int CW       = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output piton_chan_t       chan_out,
    input  piton_chan_t       chan_in,
    output logic [FLIT_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [CW-1:0]     credit_cnt_o,
    output logic              rx_overflow_o,
    output logic              credit_err_o,
    output logic [31:0]       tx_flits_o,
    output logic [31:0]       rx_flits_o
);

    localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

    logic [CW-1:0]  credit;
    logic           accept;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [RX_AW:0] fifo_count;

    // Ready comes only from the registered count, so a yummy cannot reach tx_ready_o in the same cycle.
    assign tx_ready_o   = (credit != '0);
    assign accept       = tx_valid_i & tx_ready_o;
    assign rx_valid_o   = ~fifo_empty;
    assign pop          = rx_valid_o & rx_ready_i;
    assign credit_cnt_o = credit;

    piton_port_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (chan_in.valid),
        .push_data (chan_in.data),
        .pop       (pop),
        .pop_data  (rx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            credit        <= CW'(CREDITS);
            credit_err_o  <= 1'b0;
            rx_overflow_o <= 1'b0;
            chan_out      <= '0;
        end else begin
            unique case ({accept, chan_in.yummy})
                2'b10: credit <= credit - CW'(1);
                2'b01: begin
                    if (credit == CW'(CREDITS)) credit_err_o <= 1'b1;
                    else                        credit       <= credit + CW'(1);
                end
                default: credit <= credit;
            endcase

            if (chan_in.valid & fifo_full & ~pop) rx_overflow_o <= 1'b1;

            chan_out.valid <= accept;
            chan_out.yummy <= pop;
            if (accept) chan_out.data <= tx_data_i;
        end
    end

`ifdef PITON_PORT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_flits_o <= '0;
            rx_flits_o <= '0;
        end else begin
            if (accept)        tx_flits_o <= tx_flits_o + 32'd1;
            if (chan_in.valid) rx_flits_o <= rx_flits_o + 32'd1;
        end
    end
`else
    assign tx_flits_o = '0;
    assign rx_flits_o = '0;
`endif

    // The FIFO can never report more entries than it has slots.
    assert property (@(posedge clk) disable iff (reset) fifo_count <= (RX_AW+1)'(RX_DEPTH));

endmodule
